// File: rtl/axi_to_reg_bridge_if.sv
// ---------------------------------------------------------------------------
// AXI_BUS
// Trimmed AXI4 bus interface carrying only the channel fields the register
// bridge consumes or produces (id, addr, len, size, burst, user and the
// handshakes). Lock/cache/prot/qos/region are not present because a terminal
// register slave has no use for them.
//
// Modports:
//   Master - drives AW/W/AR and the B/R ready signals.
//   Slave  - drives the AW/W/AR ready signals and the B/R channels.
// ---------------------------------------------------------------------------
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 12,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_to_reg_bridge.sv
// ---------------------------------------------------------------------------
// axi_to_reg_bridge
// Terminal AXI4 slave that turns AXI bursts into single-beat accesses on a
// simple request/ready register bus. One transaction is in flight at a time;
// read and write address channels are arbitrated round-robin.
//
// Ports:
//   clk_i        - clock
//   rst_i        - asynchronous active-high reset
//   slave        - AXI4 slave port (AXI_BUS.Slave)
//   reg_req_o    - register access request
//   reg_we_o     - 1 = write, 0 = read
//   reg_addr_o   - beat address
//   reg_wdata_o  - write data
//   reg_be_o     - byte enables (wstrb on writes, all ones on reads)
//   reg_ready_i  - access completes when reg_req_o && reg_ready_i
//   reg_rdata_i  - read data, valid in the completing cycle
//   reg_error_i  - access error, valid in the completing cycle
//
// Optional build macro:
//   AXI_TO_REG_ADDR_CHECK_EN - adds REG_BASE/REG_SIZE; beats outside the
//   window skip the register access and respond DECERR.
// ---------------------------------------------------------------------------
module axi_to_reg_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 12,
  parameter int unsigned AXI_USER_WIDTH = 1
`ifdef AXI_TO_REG_ADDR_CHECK_EN
  ,
  parameter logic [AXI_ADDR_WIDTH-1:0] REG_BASE = '0,
  parameter logic [AXI_ADDR_WIDTH:0]   REG_SIZE = (AXI_ADDR_WIDTH+1)'(4096)
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  AXI_BUS.Slave                       slave,
  output logic                        reg_req_o,
  output logic                        reg_we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] reg_be_o,
  input  logic                        reg_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rdata_i,
  input  logic                        reg_error_i
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  MAX_SIZE   = 3'($clog2(STRB_WIDTH));

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_REQ  = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;

  logic [2:0]                state_q;
  logic                      prefer_write_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [7:0]                beat_cnt_q;
  logic                      unsupported_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                rresp_q;
  logic [1:0]                sticky_q;

  logic                      grant_write;
  logic                      grant_read;
  logic                      in_range;
  logic                      access_ok;
  logic                      beat_done;
  logic                      last_beat;
  logic [1:0]                beat_resp;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic                      unused_inputs;

  // WRAP and the reserved burst encoding are both refused, as is any beat
  // wider than the data bus.
  function automatic logic is_unsupported(input logic [1:0] burst,
                                          input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'b11) || (size > MAX_SIZE);
  endfunction

  // Round-robin only matters when both address channels are valid; a lone
  // request is always granted.
  assign grant_write = slave.aw_valid && (!slave.ar_valid || prefer_write_q);
  assign grant_read  = slave.ar_valid && (!slave.aw_valid || !prefer_write_q);

`ifdef AXI_TO_REG_ADDR_CHECK_EN
  // Compare one bit wider than the address so a window ending at the top of
  // the address space does not overflow.
  logic [AXI_ADDR_WIDTH:0] addr_ext;
  logic [AXI_ADDR_WIDTH:0] base_ext;
  logic [AXI_ADDR_WIDTH:0] limit_ext;
  assign addr_ext  = {1'b0, addr_q};
  assign base_ext  = {1'b0, REG_BASE};
  assign limit_ext = base_ext + REG_SIZE;
  assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);
`else
  assign in_range  = 1'b1;
`endif

  // A beat that makes no register access finishes in its request cycle.
  assign access_ok = !unsupported_q && in_range;
  assign beat_done = access_ok ? reg_ready_i : 1'b1;
  assign last_beat = (beat_cnt_q == len_q);
  assign next_addr = (burst_q == BURST_FIXED) ? addr_q
                   : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);

  // Response of the beat currently in a request state; an address-window
  // miss outranks every other error.
  always_comb begin
    beat_resp = RESP_OKAY;
    if (!in_range) begin
      beat_resp = RESP_DECERR;
    end else if (unsupported_q || reg_error_i) begin
      beat_resp = RESP_SLVERR;
    end
  end

  assign reg_req_o   = ((state_q == RD_REQ) || (state_q == WR_REQ)) && access_ok;
  assign reg_we_o    = (state_q == WR_REQ);
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_be_o    = (state_q == WR_REQ) ? wstrb_q : {STRB_WIDTH{1'b1}};

  // Address readies are gated by reset so nothing is accepted while rst_i
  // is asserted, even though they depend combinationally on the valids.
  assign slave.aw_ready = !rst_i && (state_q == IDLE) && grant_write;
  assign slave.ar_ready = !rst_i && (state_q == IDLE) && grant_read;
  assign slave.w_ready  = (state_q == WR_DATA);

  assign slave.b_valid  = (state_q == WR_RESP);
  assign slave.b_resp   = sticky_q;
  assign slave.b_id     = id_q;
  assign slave.b_user   = {AXI_USER_WIDTH{1'b0}};

  assign slave.r_valid  = (state_q == RD_RESP);
  assign slave.r_data   = rdata_q;
  assign slave.r_resp   = rresp_q;
  assign slave.r_last   = last_beat;
  assign slave.r_id     = id_q;
  assign slave.r_user   = {AXI_USER_WIDTH{1'b0}};

  // Beat count comes from the latched len, so w_last and user fields are
  // not needed.
  assign unused_inputs = ^{slave.w_last, slave.w_user, slave.aw_user, slave.ar_user};

  // Main transaction FSM and beat datapath.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      prefer_write_q <= 1'b1;
      id_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      beat_cnt_q     <= '0;
      unsupported_q  <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rdata_q        <= '0;
      rresp_q        <= RESP_OKAY;
      sticky_q       <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_write) begin
            id_q          <= slave.aw_id;
            addr_q        <= slave.aw_addr;
            len_q         <= slave.aw_len;
            size_q        <= slave.aw_size;
            burst_q       <= slave.aw_burst;
            unsupported_q <= is_unsupported(slave.aw_burst, slave.aw_size);
            beat_cnt_q    <= '0;
            sticky_q      <= RESP_OKAY;
            state_q       <= WR_DATA;
            if (slave.ar_valid) prefer_write_q <= 1'b0;
          end else if (grant_read) begin
            id_q          <= slave.ar_id;
            addr_q        <= slave.ar_addr;
            len_q         <= slave.ar_len;
            size_q        <= slave.ar_size;
            burst_q       <= slave.ar_burst;
            unsupported_q <= is_unsupported(slave.ar_burst, slave.ar_size);
            beat_cnt_q    <= '0;
            state_q       <= RD_REQ;
            if (slave.aw_valid) prefer_write_q <= 1'b1;
          end
        end
        RD_REQ: begin
          if (beat_done) begin
            rdata_q <= access_ok ? reg_rdata_i : '0;
            rresp_q <= beat_resp;
            state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (slave.r_ready) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
              addr_q     <= next_addr;
              state_q    <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (slave.w_valid) begin
            wdata_q <= slave.w_data;
            wstrb_q <= slave.w_strb;
            state_q <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (beat_done) begin
            // OKAY=00, SLVERR=10, DECERR=11: OR-ing keeps the worst response
            // seen so far, with DECERR winning over SLVERR.
            sticky_q <= sticky_q | beat_resp;
            if (last_beat) begin
              state_q <= WR_RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
              addr_q     <= next_addr;
              state_q    <= WR_DATA;
            end
          end
        end
        WR_RESP: begin
          if (slave.b_ready) begin
            sticky_q <= RESP_OKAY;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_to_reg_bridge.md
Name: axi_to_reg_bridge

Overview:
- Terminal AXI4 slave that connects to one master port of the node wrapper, after the port's multicut slice.
- Converts AXI bursts into single-beat accesses on a simple register request/ready bus, for peripheral register files.
- Handles one transaction at a time: no reordering, no outstanding-ID tracking.
- Read and write channels are arbitrated round-robin.

Parameters:
- AXI_ADDR_WIDTH, 32: AXI and register address width.
- AXI_DATA_WIDTH, 32: AXI and register data width; power of two, at least 8.
- AXI_ID_WIDTH, 12: slave ID width (node slave ID width plus clog2 of slave count).
- AXI_USER_WIDTH, 1: user width; user signals are ignored; outgoing user signals are driven 0.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- slave, AXI_BUS.Slave, interface: incoming AXI4 port, parameterised as above.
- reg_req_o, output, 1: register access request.
- reg_we_o, output, 1: 1 = write, 0 = read.
- reg_addr_o, output, AXI_ADDR_WIDTH: beat address.
- reg_wdata_o, output, AXI_DATA_WIDTH: write data.
- reg_be_o, output, AXI_DATA_WIDTH/8: byte enables; equal to wstrb on writes, all ones on reads.
- reg_ready_i, input, 1: access completes in any cycle where reg_req_o and reg_ready_i are both high.
- reg_rdata_i, input, AXI_DATA_WIDTH: read data, valid in the completing cycle.
- reg_error_i, input, 1: access error, valid in the completing cycle.

Behaviour:
- Reset, asynchronous (rst_i high):
  - All outputs are 0: aw_ready, w_ready, ar_ready, b_valid, r_valid, reg_req_o.
  - FSM goes to IDLE; round-robin pointer prefers write.
  - Reset mid-burst drops the transaction silently; no response is issued.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_REQ, WR_RESP.
- IDLE:
  - ar_ready and aw_ready are high only for the channel selected by arbitration.
  - If only one of aw_valid / ar_valid is high, that channel is accepted.
  - If both are high, the channel not served last is accepted, and the pointer then toggles.
  - On acceptance, latch id, addr, len, size and burst.
  - Next state is RD_REQ for a read, WR_DATA for a write.
- Beat address:
  - First beat uses the AXI address.
  - Each subsequent beat adds 2^size.
  - FIXED bursts keep the address constant.
  - INCR bursts wrap modulo 2^AXI_ADDR_WIDTH; 4 KB boundary crossing is not checked.
- WRAP bursts, or size greater than log2(AXI_DATA_WIDTH/8):
  - Unsupported: no register access is made.
  - Reads return len+1 beats with rresp SLVERR and rdata 0.
  - Writes consume all W beats, then respond bresp SLVERR.
- RD_REQ:
  - reg_req_o=1, reg_we_o=0.
  - On completion, capture rdata and error into the R output registers; go to RD_RESP.
- RD_RESP:
  - r_valid=1; rresp is SLVERR if the captured error is set, else OKAY.
  - r_last=1 on beat len; r_id is the latched ID.
  - On r_ready: go to IDLE if this was the last beat, else to RD_REQ with the next address.
  - Read latency: at least 1 cycle from reg_ready_i to r_valid. Back-to-back beats take at least 2 cycles each.
- WR_DATA:
  - w_ready=1. On w_valid, capture wdata and wstrb; go to WR_REQ.
- WR_REQ:
  - reg_req_o=1, reg_we_o=1.
  - On completion, OR the error into a sticky error bit.
  - Go to WR_RESP if this was the last beat, else to WR_DATA.
  - The beat count comes from awlen; the w_last value is ignored.
- WR_RESP:
  - b_valid=1; bresp is SLVERR if the sticky bit is set, else OKAY; b_id is the latched ID.
  - On b_ready: clear the sticky bit and go to IDLE.
- reg_req_o stays asserted with all register outputs stable until reg_ready_i is high; there is no timeout.
- r_valid and b_valid stay high with stable payload until accepted, per AXI.
- Beat counter is 8 bits and supports len 0..255.

Optional Feature:
- Macro: AXI_TO_REG_ADDR_CHECK_EN.
- Defined:
  - Adds parameters REG_BASE (default 0) and REG_SIZE (default 4096).
  - Any beat address outside [REG_BASE, REG_BASE+REG_SIZE) suppresses reg_req_o for that beat.
  - That beat is treated as an error with DECERR (2'b11) instead of SLVERR: rresp per beat, bresp sticky.
  - Within a write burst, DECERR takes precedence over SLVERR.
- Undefined: no range check; every supported beat issues a register access.

Test Plan:
- Single read, AR addr=0x10, len=0, size=2, id=5, reg_ready_i high one cycle later with rdata=0xDEADBEEF → one R beat: rdata=0xDEADBEEF, rid=5, rresp=OKAY, rlast=1.
- INCR write, addr=0x100, len=3, size=2, wstrb=0xF → reg accesses at 0x100, 0x104, 0x108, 0x10C with matching wdata → one B with bresp=OKAY.
- Same write with reg_error_i=1 on beat 2 only → all 4 accesses still made → bresp=SLVERR. A following write with no errors → bresp=OKAY.
- aw_valid and ar_valid asserted together for 4 consecutive transactions → grants alternate W, R, W, R.
- WRAP read, len=3 → no reg_req_o → 4 R beats, each rresp=SLVERR, rlast only on the 4th.
- rst_i asserted while in RD_RESP with r_valid=1 → r_valid and reg_req_o drop to 0 immediately; the next transaction after reset completes normally.
